pc_fetch_sync: RTL

- Clocked consumer at the far end of the asynchronous program counter's output handshake. It samples the PC address and returns the ack and the increment (`inc`) to the PC.
- Fetches the 1–3 byte instruction at that address from a synchronous instruction memory.
- Hands the assembled instruction to the decode stage over a valid/ready interface.
- Bridges the self-timed PC ring into the clocked datapath using fixed, parameterised settle and ack-hold windows.

---
 rtl/pc_fetch_sync_pkg.sv | 32 +++
 rtl/pc_fetch_sync_hs_window_timer.sv | 30 +++
 rtl/pc_fetch_sync.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pc_fetch_sync_pkg.sv
// Shared types and helpers for the PC-to-decode fetch bridge.
package pc_fetch_sync_pkg;

    typedef enum logic [2:0] {
        SETTLE,
        CAPTURE,
        REQ,
        WAIT,
        OUT,
        ACK
    } fetch_state_t;

    localparam logic [1:0] LEN1 = 2'b00;
    localparam logic [1:0] LEN2 = 2'b01;
    localparam logic [1:0] LEN3 = 2'b10;
    localparam logic [1:0] LENR = 2'b11;

    // Instruction length in bytes from the top two bits of the first byte;
    // the reserved code behaves as a single-byte instruction.
    function automatic logic [1:0] len_decode(input logic [7:0] byte0);
        logic [1:0] len;
        case (byte0[7:6])
            LEN1:    len = 2'd1;
            LEN2:    len = 2'd2;
            LEN3:    len = 2'd3;
            LENR:    len = 2'd1;
            default: len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/pc_fetch_sync_hs_window_timer.sv
// Loadable down-counter used to time the PC settle and ack-hold windows.
module hs_window_timer #(
    parameter int            W           = 3,
    parameter logic [W-1:0]  RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] count_q;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_VALUE;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0);

endmodule

// File: rtl/pc_fetch_sync.sv
// Clocked consumer of the self-timed PC handshake: captures the PC address,
// fetches a 1-3 byte instruction, presents it to decode, then acks the PC.
module pc_fetch_sync
    import pc_fetch_sync_pkg::*;
#(
    parameter int AW            = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int ACK_CYCLES    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_addr,
    output logic          pc_ack,
    output logic [1:0]    pc_inc,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [23:0]   out_instr,
    output logic [1:0]    out_len
);

    // The ACK window is loaded with ACK_CYCLES rather than ACK_CYCLES-1: its
    // first cycle keeps pc_ack low so the freshly updated pc_inc has a full
    // clock to reach the PC adder before the ack edge.
    localparam int TMAX = ((SETTLE_CYCLES - 1) > ACK_CYCLES) ? (SETTLE_CYCLES - 1) : ACK_CYCLES;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] ACK_LOAD    = TW'(ACK_CYCLES);

    fetch_state_t  state, state_next;
    logic [AW-1:0] base;
    logic [1:0]    k;
    logic [1:0]    len_q;
    logic [23:0]   instr_q;
    logic [1:0]    inc_q;

    logic [1:0]    cur_len;
    logic          more_bytes;
    logic          accept;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic [TW-1:0] timer_count;
    logic          timer_done;

    assign accept      = (state == OUT) && out_ready;
    assign cur_len     = (k == 2'd0) ? len_decode(mem_data) : len_q;
    assign more_bytes  = ({1'b0, k} + 3'd1) < {1'b0, cur_len};
    assign timer_load  = accept || ((state == ACK) && timer_done);
    assign timer_value = (state == OUT) ? ACK_LOAD : SETTLE_LOAD;

    hs_window_timer #(
        .W           (TW),
        .RESET_VALUE (SETTLE_LOAD)
    ) u_window_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .count      (timer_count),
        .done       (timer_done)
    );

    // State register; reset drops any transaction in flight back to SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing for one PC transaction.
    always_comb begin
        state_next = state;
        case (state)
            SETTLE:  if (timer_done) state_next = CAPTURE;
            CAPTURE: state_next = REQ;
            REQ:     state_next = WAIT;
            WAIT:    state_next = more_bytes ? REQ : OUT;
            OUT:     if (accept) state_next = ACK;
            ACK:     if (timer_done) state_next = SETTLE;
            default: state_next = SETTLE;
        endcase
    end

    // Fetch datapath: latch the base address, assemble bytes, update the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base    <= '0;
            k       <= 2'd0;
            len_q   <= 2'd1;
            instr_q <= 24'h0;
            inc_q   <= 2'd1;
        end else begin
            case (state)
                CAPTURE: begin
                    base    <= pc_addr;
                    k       <= 2'd0;
                    len_q   <= 2'd1;
                    instr_q <= 24'h0;
                end
                WAIT: begin
                    case (k)
                        2'd0:    instr_q[23:16] <= mem_data;
                        2'd1:    instr_q[15:8]  <= mem_data;
                        default: instr_q[7:0]   <= mem_data;
                    endcase
                    if (k == 2'd0) begin
                        len_q <= len_decode(mem_data);
                    end
                    if (more_bytes) begin
                        k <= k + 2'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        inc_q <= len_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pc_ack    = (state == ACK) && (timer_count < ACK_LOAD);
    assign pc_inc    = inc_q;
    assign mem_rd    = (state == REQ);
    assign mem_addr  = base + AW'(k);
    assign out_valid = (state == OUT);
    assign out_instr = instr_q;
    assign out_len   = len_q;

endmodule
